hot_query_scheduler: RTL and testbench
======================================

# hot_query_scheduler

Epoch-driven controller that sequences two page-hotness tracker channels (each an address FIFO plus hot tracker core). On every epoch expiry or software trigger it issues one lock-step query to both trackers, collects both top-5 result sets, and streams the eligible hot addresses, up to the configured migration count per channel, one at a time over a valid/ready migration-request port. It sits between the CSR block and the trackers, and owns the trackers' `query_en`, `query_cmd`, `both_query_ready` and `num_mig` inputs.

## Interface
- ADDR_SIZE, 28, tracker address width
- CNT_SIZE, 13, hotness count width
- CMD_WIDTH, 4, query command width
- EPOCH_BITS, 32, epoch counter width
- TIMEOUT, 4096, maximum WAIT cycles before abort
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_enable  in  1  scheduler enable
- cfg_epoch  in  EPOCH_BITS  epoch length in cycles; 0 means software trigger only
- cfg_threshold  in  CNT_SIZE  minimum count for an entry to be emitted
- cfg_num_mig  in  3  entries per channel to consider; values above 5 clamp to 5
- sw_trigger  in  1  one-cycle request for an immediate query
- query_en  out  1  query strobe to both trackers
- query_cmd  out  CMD_WIDTH  command; 4'd1 = QUERY_TOP
- t0_query_ready, t1_query_ready  in  1  tracker ready inputs
- both_query_ready  out  1  t0_query_ready & t1_query_ready, fed back to both trackers
- num_mig  out  3  clamped entry count latched at issue, driven to both trackers
- t0_mig_en, t1_mig_en  in  1  one-cycle result-valid pulses
- t0_top_addr, t1_top_addr  in  5*ADDR_SIZE  entry k (k=0 is hottest) at [k*ADDR_SIZE +: ADDR_SIZE]
- t0_top_cnt, t1_top_cnt  in  5*CNT_SIZE  entry k at [k*CNT_SIZE +: CNT_SIZE]
- mig_valid  out  1  migration request valid
- mig_ready  in  1  migration request accept
- mig_addr  out  ADDR_SIZE  hot address
- mig_cnt  out  CNT_SIZE  its count
- mig_src  out  1  channel (0/1)
- busy  out  1  state != IDLE
- epoch_done  out  1  one-cycle pulse at end of each round
- err_timeout  out  1  sticky; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, SCAN, EMIT, DONE.
- Epoch counter runs while cfg_enable=1 and cfg_epoch!=0, and is held at 0 otherwise. At cfg_epoch-1 it wraps to 0 and raises `fire`.
- `pending` is set by `fire` or sw_trigger in any state other than IDLE. Multiple triggers coalesce into a single pending request.
- IDLE: if cfg_enable & (pending | fire | sw_trigger), go to ISSUE. Latch n = min(cfg_num_mig, 5) into num_mig and clear pending.
- ISSUE: query_en=1 and query_cmd=1. The handshake completes when query_en & t0_query_ready & t1_query_ready; then go to WAIT.
- WAIT: on t0_mig_en, capture the t0 buses and set got0; t1 is handled the same way (got1). Pulses may coincide or arrive in either order. A repeat pulse overwrites the captured data.
  - When got0 & got1, go to SCAN with idx=0.
  - When the wait counter reaches TIMEOUT-1, set err_timeout and go to DONE with no emission.
- SCAN: the idx range is 0..2n-1. idx<n selects t0 entry idx; otherwise t1 entry idx-n.
  - If idx==2n, go to DONE.
  - Else if the entry count >= cfg_threshold and count != 0, register mig_addr/cnt/src and go to EMIT.
  - Else idx++ and stay in SCAN.
- EMIT: mig_valid=1 with payload held stable. On mig_ready, idx++ and go to SCAN.
- DONE: epoch_done=1 for one cycle, clear got0/got1, go to IDLE.
- cfg_enable deasserted mid-round: the current round completes, and no new round starts.
- n=0: the round goes straight from SCAN to DONE with no mig_valid.

## Timing
- Reset values: all outputs 0, state IDLE, pending=0, epoch counter 0. num_mig and query_cmd are also 0.
- All outputs are registered or Moore-decoded from state; there is no input-to-output combinational path except both_query_ready.
- Trigger sampled at edge t: query_en is high in cycle t+1.
- Each WAIT capture occurs in the mig_en cycle. SCAN is entered on the cycle after the later capture.
- Each skipped entry costs 1 cycle. Each emitted entry costs at least 2 cycles (SCAN + EMIT).
- query_cmd reads 1 only while query_en=1 and reads 0 otherwise.
- Asynchronous reset mid-round aborts immediately to the reset values; no epoch_done is produced.

## Test plan
- cfg_epoch=100, n=2, threshold=0, both trackers ready, both mig_en 5 cycles after query: query_en pulses every 100 cycles; 4 requests ordered t0[0], t0[1], t1[0], t1[1]; epoch_done once per round.
- t1_query_ready low for 20 cycles: query_en stays high 20+ cycles; the handshake completes on the first cycle both are ready; both_query_ready tracks the AND exactly.
- threshold=50, t0 counts {80,50,49,0,0}, t1 counts {10,...}, n=5: exactly 2 requests (counts 80, 50, src 0).
- mig_ready held low 10 cycles in EMIT: mig_valid, addr, cnt and src are stable for all 10 cycles, then advance on the accept.
- t1_mig_en never asserted, TIMEOUT=64: err_timeout sets after 64 WAIT cycles; no mig_valid; epoch_done pulses; the next trigger still runs a round.
- sw_trigger twice plus an epoch fire during EMIT: exactly one further round follows immediately after DONE; cfg_num_mig=7 drives num_mig=5.

Source files
------------

// File: rtl/hot_query_scheduler.sv
// Epoch/software-triggered query sequencer for two hot-page tracker channels.
// Issues one lock-step query, collects both top-5 lists, streams eligible entries.
module hot_query_scheduler #(
  parameter int ADDR_SIZE  = 28,
  parameter int CNT_SIZE   = 13,
  parameter int CMD_WIDTH  = 4,
  parameter int EPOCH_BITS = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_enable,
  input  logic [EPOCH_BITS-1:0]   cfg_epoch,
  input  logic [CNT_SIZE-1:0]     cfg_threshold,
  input  logic [2:0]              cfg_num_mig,
  input  logic                    sw_trigger,
  output logic                    query_en,
  output logic [CMD_WIDTH-1:0]    query_cmd,
  input  logic                    t0_query_ready,
  input  logic                    t1_query_ready,
  output logic                    both_query_ready,
  output logic [2:0]              num_mig,
  input  logic                    t0_mig_en,
  input  logic                    t1_mig_en,
  input  logic [5*ADDR_SIZE-1:0]  t0_top_addr,
  input  logic [5*ADDR_SIZE-1:0]  t1_top_addr,
  input  logic [5*CNT_SIZE-1:0]   t0_top_cnt,
  input  logic [5*CNT_SIZE-1:0]   t1_top_cnt,
  output logic                    mig_valid,
  input  logic                    mig_ready,
  output logic [ADDR_SIZE-1:0]    mig_addr,
  output logic [CNT_SIZE-1:0]     mig_cnt,
  output logic                    mig_src,
  output logic                    busy,
  output logic                    epoch_done,
  output logic                    err_timeout
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CMD_WIDTH-1:0] QUERY_TOP = CMD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SCAN, S_EMIT, S_DONE
  } state_t;

  state_t                  r_state;
  logic [EPOCH_BITS-1:0]   r_epochCnt;
  logic                    r_pending;
  logic                    r_got0;
  logic                    r_got1;
  logic [WAIT_W-1:0]       r_waitCnt;
  logic [3:0]              r_idx;
  logic [5*ADDR_SIZE-1:0]  r_t0Addr;
  logic [5*ADDR_SIZE-1:0]  r_t1Addr;
  logic [5*CNT_SIZE-1:0]   r_t0Cnt;
  logic [5*CNT_SIZE-1:0]   r_t1Cnt;

  logic                    w_epochRun;
  logic                    w_fire;
  logic                    w_trig;
  logic                    w_hs;
  logic [2:0]              w_clampN;
  logic [3:0]              w_twoN;
  logic                    w_fromT1;
  logic [2:0]              w_entry;
  logic [ADDR_SIZE-1:0]    w_selAddr;
  logic [CNT_SIZE-1:0]     w_selCnt;
  logic                    w_eligible;

  assign both_query_ready = t0_query_ready & t1_query_ready;
  assign w_epochRun = cfg_enable & (cfg_epoch != '0);
  assign w_fire     = w_epochRun & (r_epochCnt >= (cfg_epoch - EPOCH_BITS'(1)));
  assign w_trig     = w_fire | sw_trigger;
  assign w_hs       = query_en & t0_query_ready & t1_query_ready;
  assign w_clampN   = (cfg_num_mig > 3'd5) ? 3'd5 : cfg_num_mig;
  assign w_twoN     = {num_mig, 1'b0};

  // Epoch counter is held at zero whenever periodic triggering is off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_epochCnt <= '0;
    end else if (!w_epochRun || w_fire) begin
      r_epochCnt <= '0;
    end else begin
      r_epochCnt <= r_epochCnt + EPOCH_BITS'(1);
    end
  end

  // Scan index walks t0 entries 0..n-1, then t1 entries 0..n-1.
  always_comb begin
    w_fromT1  = 1'b0;
    w_entry   = r_idx[2:0];
    w_selAddr = '0;
    w_selCnt  = '0;
    if (r_idx >= {1'b0, num_mig}) begin
      w_fromT1 = 1'b1;
      w_entry  = 3'(r_idx - {1'b0, num_mig});
    end
    for (int k = 0; k < 5; k++) begin
      if (w_entry == 3'(k)) begin
        w_selAddr = w_fromT1 ? r_t1Addr[k*ADDR_SIZE +: ADDR_SIZE] : r_t0Addr[k*ADDR_SIZE +: ADDR_SIZE];
        w_selCnt  = w_fromT1 ? r_t1Cnt[k*CNT_SIZE +: CNT_SIZE]    : r_t0Cnt[k*CNT_SIZE +: CNT_SIZE];
      end
    end
  end

  assign w_eligible = (w_selCnt >= cfg_threshold) && (w_selCnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_got0      <= 1'b0;
      r_got1      <= 1'b0;
      r_waitCnt   <= '0;
      r_idx       <= '0;
      r_t0Addr    <= '0;
      r_t1Addr    <= '0;
      r_t0Cnt     <= '0;
      r_t1Cnt     <= '0;
      query_en    <= 1'b0;
      query_cmd   <= '0;
      num_mig     <= '0;
      mig_valid   <= 1'b0;
      mig_addr    <= '0;
      mig_cnt     <= '0;
      mig_src     <= 1'b0;
      busy        <= 1'b0;
      epoch_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      epoch_done <= 1'b0;
      if (w_trig && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (cfg_enable && (r_pending || w_trig)) begin
            num_mig   <= w_clampN;
            r_pending <= 1'b0;
            query_en  <= 1'b1;
            query_cmd <= QUERY_TOP;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            query_en  <= 1'b0;
            query_cmd <= '0;
            r_waitCnt <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (t0_mig_en) begin
            r_t0Addr <= t0_top_addr;
            r_t0Cnt  <= t0_top_cnt;
            r_got0   <= 1'b1;
          end
          if (t1_mig_en) begin
            r_t1Addr <= t1_top_addr;
            r_t1Cnt  <= t1_top_cnt;
            r_got1   <= 1'b1;
          end
          // A capture in this very cycle counts, so SCAN follows the later capture directly.
          if ((r_got0 || t0_mig_en) && (r_got1 || t1_mig_en)) begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end else if (r_waitCnt == WAIT_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            epoch_done  <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        S_SCAN: begin
          if (r_idx == w_twoN) begin
            epoch_done <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_eligible) begin
            mig_addr  <= w_selAddr;
            mig_cnt   <= w_selCnt;
            mig_src   <= w_fromT1;
            mig_valid <= 1'b1;
            r_state   <= S_EMIT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_EMIT: begin
          if (mig_ready) begin
            mig_valid <= 1'b0;
            r_idx     <= r_idx + 4'd1;
            r_state   <= S_SCAN;
          end
        end
        S_DONE: begin
          r_got0  <= 1'b0;
          r_got1  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hot_query_scheduler.sv
// Directed-plus-random bench for hot_query_scheduler; emulates both trackers and
// compares every migration request against a list built from the selection rules.
module tb_hot_query_scheduler;

  localparam int AW = 28;
  localparam int CW = 13;

  typedef struct {
    logic          src;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } req_t;

  logic            clk;
  logic            rstn;
  logic            cfg_enable;
  logic [31:0]     cfg_epoch;
  logic [CW-1:0]   cfg_threshold;
  logic [2:0]      cfg_num_mig;
  logic            sw_trigger;
  logic            query_en;
  logic [3:0]      query_cmd;
  logic            t0_query_ready;
  logic            t1_query_ready;
  logic            both_query_ready;
  logic [2:0]      num_mig;
  logic            t0_mig_en;
  logic            t1_mig_en;
  logic [5*AW-1:0] t0_top_addr;
  logic [5*AW-1:0] t1_top_addr;
  logic [5*CW-1:0] t0_top_cnt;
  logic [5*CW-1:0] t1_top_cnt;
  logic            mig_valid;
  logic            mig_ready;
  logic [AW-1:0]   mig_addr;
  logic [CW-1:0]   mig_cnt;
  logic            mig_src;
  logic            busy;
  logic            epoch_done;
  logic            err_timeout;

  int cycleNo    = 0;
  int passCount  = 0;
  int checkCount = 0;

  hot_query_scheduler #(
    .ADDR_SIZE(AW), .CNT_SIZE(CW), .CMD_WIDTH(4), .EPOCH_BITS(32), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_epoch(cfg_epoch),
    .cfg_threshold(cfg_threshold), .cfg_num_mig(cfg_num_mig), .sw_trigger(sw_trigger),
    .query_en(query_en), .query_cmd(query_cmd), .t0_query_ready(t0_query_ready),
    .t1_query_ready(t1_query_ready), .both_query_ready(both_query_ready), .num_mig(num_mig),
    .t0_mig_en(t0_mig_en), .t1_mig_en(t1_mig_en), .t0_top_addr(t0_top_addr),
    .t1_top_addr(t1_top_addr), .t0_top_cnt(t0_top_cnt), .t1_top_cnt(t1_top_cnt),
    .mig_valid(mig_valid), .mig_ready(mig_ready), .mig_addr(mig_addr), .mig_cnt(mig_cnt),
    .mig_src(mig_src), .busy(busy), .epoch_done(epoch_done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulseTrigger(output int trigCyc);
    sw_trigger = 1'b1;
    trigCyc = cycleNo;
    tick();
    sw_trigger = 1'b0;
  endtask

  // One full round: waits for the query, plays both trackers, drains requests against the model.
  task automatic applyStimulus(input int thr, input int t1Delay, input bit t1Never, input int holdLow,
                               input bit fixedCounts, input bit trigEmit,
                               output int riseCyc, output int doneCyc, output int nReq);
    logic [AW-1:0] a0[5];
    logic [AW-1:0] a1[5];
    logic [CW-1:0] c0[5];
    logic [CW-1:0] c1[5];
    logic [CW-1:0] cnt;
    req_t expQ[$];
    req_t e;
    req_t prev;
    int expN, expTotal, waitCyc, d0, d1, maxD, hsCyc, lowLeft;
    bit garbage, doneSeen, hadPrev, ready;

    riseCyc = 0; doneCyc = 0; nReq = 0;
    cfg_threshold = CW'(thr);
    expN = (cfg_num_mig > 3'd5) ? 5 : int'(cfg_num_mig);
    waitCyc = 0;
    while (query_en !== 1'b1 && waitCyc < 300) begin
      tick();
      waitCyc++;
    end
    checkOutput("query_start", 64'(query_en), 64'd1);
    if (query_en !== 1'b1) return;
    riseCyc = cycleNo;
    checkOutput("query_cmd_issue", 64'(query_cmd), 64'd1);
    checkOutput("busy_issue", 64'(busy), 64'd1);

    t0_query_ready = 1'b1;
    t1_query_ready = (t1Delay == 0);
    for (int c = 0; c < t1Delay; c++) begin
      #1;
      checkOutput("bqr_and_low", 64'(both_query_ready), 64'd0);
      checkOutput("qen_hold", 64'(query_en), 64'd1);
      tick();
    end
    t1_query_ready = 1'b1;
    #1 checkOutput("bqr_and_high", 64'(both_query_ready), 64'd1);
    tick();
    t0_query_ready = 1'b0;
    t1_query_ready = 1'b0;
    hsCyc = cycleNo;
    #1;
    checkOutput("qen_after_hs", 64'(query_en), 64'd0);
    checkOutput("qcmd_after_hs", 64'(query_cmd), 64'd0);
    checkOutput("num_mig", 64'(num_mig), 64'(expN));

    for (int k = 0; k < 5; k++) begin
      a0[k] = AW'($urandom);
      a1[k] = AW'($urandom);
      c0[k] = CW'($urandom_range(0, 120));
      c1[k] = CW'($urandom_range(0, 120));
    end
    c0[0] = CW'(thr + 1 + int'($urandom_range(0, 20)));
    if (fixedCounts) begin
      c0[0] = 13'd80; c0[1] = 13'd50; c0[2] = 13'd49; c0[3] = 13'd0; c0[4] = 13'd0;
      for (int k = 0; k < 5; k++) c1[k] = 13'd10;
    end
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < expN; k++) begin
        cnt = (ch == 1) ? c1[k] : c0[k];
        if (cnt != 0 && int'(cnt) >= thr) begin
          e.src = (ch == 1);
          e.addr = (ch == 1) ? a1[k] : a0[k];
          e.cnt = cnt;
          expQ.push_back(e);
        end
      end
    end
    expTotal = t1Never ? 0 : expQ.size();

    // An early stale t0 result is sent first when t1 answers late; the repeat must replace it.
    d0 = $urandom_range(2, 6);
    d1 = $urandom_range(1, 8);
    garbage = !t1Never && (d1 > d0);
    maxD = t1Never ? d0 : ((d0 > d1) ? d0 : d1);
    for (int c = 1; c <= maxD; c++) begin
      t0_mig_en = (c == d0) || (garbage && c == 1);
      t1_mig_en = !t1Never && (c == d1);
      for (int k = 0; k < 5; k++) begin
        t0_top_addr[k*AW +: AW] = (c == d0) ? a0[k] : AW'($urandom);
        t0_top_cnt[k*CW +: CW]  = (c == d0) ? c0[k] : CW'($urandom);
        t1_top_addr[k*AW +: AW] = a1[k];
        t1_top_cnt[k*CW +: CW]  = c1[k];
      end
      tick();
    end
    t0_mig_en = 1'b0;
    t1_mig_en = 1'b0;

    hadPrev = 0; lowLeft = holdLow; doneSeen = 0;
    prev.src = 1'b0; prev.addr = '0; prev.cnt = '0;
    for (int i = 0; i < 600 && !doneSeen; i++) begin
      sw_trigger = 1'b0;
      if (trigEmit) cfg_epoch = '0;
      if (epoch_done === 1'b1) begin
        doneSeen = 1;
        doneCyc = cycleNo;
      end else begin
        ready = 0;
        if (mig_valid === 1'b1) begin
          if (hadPrev) begin
            checkOutput("hold_addr", 64'(mig_addr), 64'(prev.addr));
            checkOutput("hold_cnt", 64'(mig_cnt), 64'(prev.cnt));
            checkOutput("hold_src", 64'(mig_src), 64'(prev.src));
          end
          if (lowLeft > 0) begin
            if (trigEmit) begin
              sw_trigger = (lowLeft == 9 || lowLeft == 6);
              if (lowLeft <= 8 && lowLeft >= 5) cfg_epoch = 32'd3;
            end
            lowLeft--;
          end else begin
            ready = ($urandom_range(0, 3) != 0);
          end
          if (ready) begin
            nReq++;
            if (expQ.size() > 0) begin
              e = expQ.pop_front();
              checkOutput("req_addr", 64'(mig_addr), 64'(e.addr));
              checkOutput("req_cnt", 64'(mig_cnt), 64'(e.cnt));
              checkOutput("req_src", 64'(mig_src), 64'(e.src));
            end
            hadPrev = 0;
          end else begin
            hadPrev = 1;
            prev.addr = mig_addr;
            prev.cnt = mig_cnt;
            prev.src = mig_src;
          end
        end else begin
          hadPrev = 0;
        end
        mig_ready = ready;
        tick();
      end
    end
    mig_ready = 1'b0;
    sw_trigger = 1'b0;
    checkOutput("done_seen", 64'(doneSeen), 64'd1);
    checkOutput("req_count", 64'(nReq), 64'(expTotal));
    if (t1Never) begin
      checkOutput("timeout_latency", 64'(doneCyc - hsCyc), 64'd64);
      checkOutput("err_timeout_set", 64'(err_timeout), 64'd1);
    end
  endtask

  initial begin
    int trigCyc, rise, done, nReq, prevRise, quiet;
    rstn = 1'b0; cfg_enable = 1'b0; cfg_epoch = '0; cfg_threshold = '0; cfg_num_mig = 3'd2;
    sw_trigger = 1'b0; t0_query_ready = 1'b0; t1_query_ready = 1'b0; t0_mig_en = 1'b0;
    t1_mig_en = 1'b0; t0_top_addr = '0; t1_top_addr = '0; t0_top_cnt = '0; t1_top_cnt = '0;
    mig_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst_query_en", 64'(query_en), 64'd0);
    checkOutput("rst_query_cmd", 64'(query_cmd), 64'd0);
    checkOutput("rst_num_mig", 64'(num_mig), 64'd0);
    checkOutput("rst_mig_valid", 64'(mig_valid), 64'd0);
    checkOutput("rst_mig_addr", 64'(mig_addr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_epoch_done", 64'(epoch_done), 64'd0);
    checkOutput("rst_err_timeout", 64'(err_timeout), 64'd0);
    rstn = 1'b1;
    tick();
    cfg_enable = 1'b1;

    $display("[TB] software-triggered round");
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 0, 0, 0, 0, rise, done, nReq);
    checkOutput("trig_latency", 64'(rise - trigCyc), 64'd1);

    $display("[TB] epoch-driven rounds");
    cfg_epoch = 32'd100;
    applyStimulus(0, 0, 0, 0, 0, 0, prevRise, done, nReq);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, rise, done, nReq);
      checkOutput("epoch_period", 64'(rise - prevRise), 64'd100);
      prevRise = rise;
    end
    cfg_epoch = '0;

    $display("[TB] ready stall and random rounds");
    for (int r = 0; r < 4; r++) begin
      cfg_num_mig = 3'($urandom_range(0, 7));
      pulseTrigger(trigCyc);
      applyStimulus($urandom_range(0, 60), (r == 0) ? 20 : $urandom_range(0, 3), 0, 0, 0, 0, rise, done, nReq);
    end
    cfg_num_mig = 3'd0;
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 0, 0, 0, 0, rise, done, nReq);
    checkOutput("n0_no_requests", 64'(nReq), 64'd0);

    $display("[TB] threshold filtering");
    cfg_num_mig = 3'd5;
    pulseTrigger(trigCyc);
    applyStimulus(50, 0, 0, 0, 1, 0, rise, done, nReq);
    checkOutput("thresh_count", 64'(nReq), 64'd2);

    $display("[TB] backpressure hold");
    cfg_num_mig = 3'd3;
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 0, 10, 0, 0, rise, done, nReq);

    $display("[TB] result timeout");
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 1, 0, 0, 0, rise, done, nReq);
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 0, 0, 0, 0, rise, done, nReq);
    checkOutput("err_timeout_sticky", 64'(err_timeout), 64'd1);

    $display("[TB] coalesced triggers during EMIT");
    cfg_num_mig = 3'd7;
    pulseTrigger(trigCyc);
    applyStimulus(0, 0, 0, 10, 0, 1, rise, done, nReq);
    applyStimulus(0, 0, 0, 0, 0, 0, rise, prevRise, nReq);
    checkOutput("pending_followup", 64'(rise - done), 64'd2);
    quiet = 0;
    for (int c = 0; c < 40; c++) begin
      if (query_en === 1'b1) quiet++;
      tick();
    end
    checkOutput("single_followup", 64'(quiet), 64'd0);

    $display("[TB] disabled scheduler");
    cfg_enable = 1'b0;
    pulseTrigger(trigCyc);
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      if (query_en === 1'b1) quiet++;
      tick();
    end
    checkOutput("disabled_no_round", 64'(quiet), 64'd0);

    $display("[TB] reset mid-round");
    cfg_enable = 1'b1;
    pulseTrigger(trigCyc);
    checkOutput("pre_reset_query", 64'(query_en), 64'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_rst_query_en", 64'(query_en), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_num_mig", 64'(num_mig), 64'd0);
    checkOutput("mid_rst_err", 64'(err_timeout), 64'd0);
    tick();
    checkOutput("mid_rst_no_done", 64'(epoch_done), 64'd0);
    rstn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
